pampy_control_unit: RTL and testbench

Microcoded-FSM control unit for the pamPy stack processor. Consumes the latched opcode plus datapath status (comparison flag, overflow) and drives every `CTRL_*`/`SEL_*` line of the four datapath blocks. It implements the fetch, argument, decode and execute sequence for the supported Python-bytecode subset. It instantiates beside the four blocks in the processor top level; its outputs connect one-to-one to the existing `GENERAL_CTRL_*`/`GENERAL_SEL_*` wires.

---
 rtl/pampy_pkg.sv | 68 ++++++
 rtl/pampy_opcode_decoder.sv | 36 +++
 rtl/pampy_control_unit.sv | 172 +++++++++++++++++
 tb/tb_pampy_control_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pampy_pkg.sv
// Shared types and encodings for the pamPy control unit and datapath blocks.
// Pure declarations; no latency, no flow control.
package pampy_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_ARG, S_DECODE, S_POP1, S_POP2, S_ALU,
    S_PUSH, S_JUMP, S_MEM, S_CALL, S_RET, S_HALT
  } state_t;

  // Instruction class latched at decode; selects the path through shared states.
  typedef enum logic [3:0] {
    OP_NOP, OP_CONST, OP_ARITH, OP_CMP, OP_JABS,
    OP_JIF, OP_LOADN, OP_STOREN, OP_CALL, OP_RET
  } op_class_t;

  localparam logic [7:0] OPC_NOP         = 8'h09;
  localparam logic [7:0] OPC_BINARY_ADD  = 8'h17;
  localparam logic [7:0] OPC_BINARY_SUB  = 8'h18;
  localparam logic [7:0] OPC_RETURN      = 8'h53;
  localparam logic [7:0] OPC_STORE_NAME  = 8'h5A;
  localparam logic [7:0] OPC_LOAD_CONST  = 8'h64;
  localparam logic [7:0] OPC_LOAD_NAME   = 8'h65;
  localparam logic [7:0] OPC_COMPARE     = 8'h6B;
  localparam logic [7:0] OPC_JUMP_ABS    = 8'h71;
  localparam logic [7:0] OPC_POP_JIF     = 8'h72;
  localparam logic [7:0] OPC_CALL        = 8'h83;

  localparam logic [3:0] ULA_ADD = 4'b0000;
  localparam logic [3:0] ULA_SUB = 4'b0001;
  localparam logic [3:0] ULA_LT  = 4'b0010;

  localparam logic [2:0] MUXS_ALU = 3'b000;
  localparam logic [2:0] MUXS_MEM = 3'b001;
  localparam logic [2:0] MUXS_RET = 3'b010;
  localparam logic [2:0] MUXS_ARG = 3'b011;

  localparam logic [1:0] PCSRC_UPD    = 2'b00;
  localparam logic [1:0] PCSRC_JMP    = 2'b01;
  localparam logic [1:0] PCSRC_FSTACK = 2'b10;

  typedef struct packed {
    logic       reg_instr;
    logic       reg_arg;
    logic       reg_pc;
    logic       sel_pc_updater;
    logic [1:0] sel_mux;
    logic       reg_op1;
    logic       reg_op2;
    logic       stack_comp;
    logic [3:0] sel_ula;
    logic       reg_tos_function;
    logic       stack_function;
    logic       sel_somador_subtrator;
    logic       reg_data_return;
    logic [2:0] sel_mux_stack;
    logic       reg_read_stack;
    logic       reg_write_stack;
    logic       reg_read_mem;
    logic       reg_write_mem;
    logic       sel_mux_tos;
    logic       reg_tos;
    logic       sel_tos_updater;
    logic       stack;
    logic       mem_ext;
    logic       halt;
  } ctrl_t;

endpackage

// File: rtl/pampy_opcode_decoder.sv
// Combinational opcode classifier: first execute state, instruction class, ALU op.
// Zero latency; no flow control, unknown opcodes raise illegal.
module pampy_opcode_decoder
  import pampy_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] instr,
  output state_t                start_state,
  output op_class_t             op_class,
  output logic [3:0]            alu_op,
  output logic                  illegal
);

  always_comb begin
    start_state = S_HALT;
    op_class    = OP_NOP;
    alu_op      = ULA_ADD;
    illegal     = 1'b0;
    case (instr)
      DATA_WIDTH'(OPC_NOP):        begin start_state = S_FETCH; op_class = OP_NOP;    end
      DATA_WIDTH'(OPC_LOAD_CONST): begin start_state = S_PUSH;  op_class = OP_CONST;  end
      DATA_WIDTH'(OPC_BINARY_ADD): begin start_state = S_POP1;  op_class = OP_ARITH; alu_op = ULA_ADD; end
      DATA_WIDTH'(OPC_BINARY_SUB): begin start_state = S_POP1;  op_class = OP_ARITH; alu_op = ULA_SUB; end
      DATA_WIDTH'(OPC_COMPARE):    begin start_state = S_POP1;  op_class = OP_CMP;   alu_op = ULA_LT;  end
      DATA_WIDTH'(OPC_JUMP_ABS):   begin start_state = S_JUMP;  op_class = OP_JABS;   end
      DATA_WIDTH'(OPC_POP_JIF):    begin start_state = S_JUMP;  op_class = OP_JIF;    end
      DATA_WIDTH'(OPC_LOAD_NAME):  begin start_state = S_MEM;   op_class = OP_LOADN;  end
      DATA_WIDTH'(OPC_STORE_NAME): begin start_state = S_POP1;  op_class = OP_STOREN; end
      DATA_WIDTH'(OPC_CALL):       begin start_state = S_CALL;  op_class = OP_CALL;   end
      DATA_WIDTH'(OPC_RETURN):     begin start_state = S_POP1;  op_class = OP_RET;    end
      default:                     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pampy_control_unit.sv
// Microcoded FSM sequencing fetch/arg/decode/execute for the pamPy datapath.
// Registered Moore outputs, one state per cycle; no backpressure, HALT is sticky until reset.
module pampy_control_unit
  import pampy_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] INSTR_IN,
  input  logic                  STACK_COMP_IN,
  input  logic                  OVERFLOW_IN,
  output logic                  CTRL_REG_INSTR,
  output logic                  CTRL_REG_ARG,
  output logic                  CTRL_REG_PC,
  output logic                  SEL_PC_UPDATER,
  output logic [1:0]            SEL_MUX,
  output logic                  CTRL_REG_OP1,
  output logic                  CTRL_REG_OP2,
  output logic                  CTRL_STACK_COMP,
  output logic [3:0]            SEL_ULA,
  output logic                  CTRL_REG_TOS_FUNCTION,
  output logic                  CTRL_STACK_FUNCTION,
  output logic                  SEL_SOMADOR_SUBTRATOR,
  output logic                  CTRL_REG_DATA_RETURN,
  output logic [2:0]            SEL_MUX_STACK,
  output logic                  CTRL_REG_READ_STACK,
  output logic                  CTRL_REG_WRITE_STACK,
  output logic                  CTRL_REG_READ_MEM,
  output logic                  CTRL_REG_WRITE_MEM,
  output logic                  SEL_MUX_TOS,
  output logic                  CTRL_REG_TOS,
  output logic                  SEL_TOS_UPDATER,
  output logic                  CTRL_STACK,
  output logic                  CTRL_MEM_EXT,
  output logic                  HALT
);

  state_t    state_q, nxt_state, dec_start;
  op_class_t op_q, nxt_op, dec_op;
  logic [3:0] alu_q, nxt_alu, dec_alu;
  logic      dec_illegal;
  logic      run_q;
  ctrl_t     ctrl_q;

  pampy_opcode_decoder #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .instr       (INSTR_IN),
    .start_state (dec_start),
    .op_class    (dec_op),
    .alu_op      (dec_alu),
    .illegal     (dec_illegal)
  );

  function automatic ctrl_t ctrl_for(state_t s, op_class_t op, logic [3:0] alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin c.reg_instr = 1'b1; c.reg_pc = 1'b1; c.sel_mux = PCSRC_UPD; end
      S_ARG:   begin c.reg_arg = 1'b1; c.reg_pc = 1'b1; end
      S_POP1, S_POP2: begin
        c.reg_read_stack  = 1'b1;
        c.reg_tos         = 1'b1;
        c.sel_tos_updater = 1'b1;
        c.reg_op1         = (s == S_POP1);
        c.reg_op2         = (s == S_POP2);
        c.reg_data_return = (s == S_POP1) && (op == OP_RET);
      end
      S_ALU: begin c.sel_ula = alu; c.stack_comp = (op == OP_CMP); end
      S_PUSH: begin
        c.reg_write_stack = 1'b1;
        c.stack           = 1'b1;
        c.reg_tos         = 1'b1;
        case (op)
          OP_CONST: c.sel_mux_stack = MUXS_ARG;
          OP_LOADN: c.sel_mux_stack = MUXS_MEM;
          OP_RET:   c.sel_mux_stack = MUXS_RET;
          default:  c.sel_mux_stack = MUXS_ALU;
        endcase
      end
      S_JUMP: begin c.reg_pc = 1'b1; c.sel_mux = PCSRC_JMP; end
      S_MEM: begin
        c.reg_read_mem  = (op == OP_LOADN);
        c.reg_write_mem = (op == OP_STOREN);
        c.mem_ext       = (op == OP_STOREN);
      end
      S_CALL: begin c.stack_function = 1'b1; c.reg_tos_function = 1'b1; end
      S_RET: begin c.sel_somador_subtrator = 1'b1; c.sel_mux = PCSRC_FSTACK; c.reg_pc = 1'b1; end
      S_HALT: c.halt = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt_state = state_q;
    nxt_op    = op_q;
    nxt_alu   = alu_q;
    case (state_q)
      S_FETCH:  nxt_state = S_ARG;
      S_ARG:    nxt_state = S_DECODE;
      S_DECODE: begin
        nxt_op  = dec_op;
        nxt_alu = dec_alu;
        if (dec_illegal)          nxt_state = S_HALT;
        else if (dec_op == OP_JIF) nxt_state = STACK_COMP_IN ? S_FETCH : S_JUMP;
        else                      nxt_state = dec_start;
      end
      S_POP1: begin
        case (op_q)
          OP_STOREN: nxt_state = S_MEM;
          OP_RET:    nxt_state = S_RET;
          default:   nxt_state = S_POP2;
        endcase
      end
      S_POP2:  nxt_state = S_ALU;
      // An overflowing arithmetic result must never reach the stack.
      S_ALU:   nxt_state = (op_q == OP_ARITH) ? (OVERFLOW_IN ? S_HALT : S_PUSH) : S_FETCH;
      S_PUSH:  nxt_state = S_FETCH;
      S_JUMP:  nxt_state = S_FETCH;
      S_MEM:   nxt_state = (op_q == OP_LOADN) ? S_PUSH : S_FETCH;
      S_CALL:  nxt_state = S_JUMP;
      S_RET:   nxt_state = S_PUSH;
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_HALT;
    endcase
  end

  // run_q holds the first post-reset cycle quiet so FETCH strobes start one cycle after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= OP_NOP;
      alu_q   <= ULA_ADD;
      run_q   <= 1'b0;
      ctrl_q  <= '0;
    end else if (!run_q) begin
      run_q   <= 1'b1;
      ctrl_q  <= ctrl_for(S_FETCH, op_q, alu_q);
    end else begin
      state_q <= nxt_state;
      op_q    <= nxt_op;
      alu_q   <= nxt_alu;
      ctrl_q  <= ctrl_for(nxt_state, nxt_op, nxt_alu);
    end
  end

  assign CTRL_REG_INSTR        = ctrl_q.reg_instr;
  assign CTRL_REG_ARG          = ctrl_q.reg_arg;
  assign CTRL_REG_PC           = ctrl_q.reg_pc;
  assign SEL_PC_UPDATER        = ctrl_q.sel_pc_updater;
  assign SEL_MUX               = ctrl_q.sel_mux;
  assign CTRL_REG_OP1          = ctrl_q.reg_op1;
  assign CTRL_REG_OP2          = ctrl_q.reg_op2;
  assign CTRL_STACK_COMP       = ctrl_q.stack_comp;
  assign SEL_ULA               = ctrl_q.sel_ula;
  assign CTRL_REG_TOS_FUNCTION = ctrl_q.reg_tos_function;
  assign CTRL_STACK_FUNCTION   = ctrl_q.stack_function;
  assign SEL_SOMADOR_SUBTRATOR = ctrl_q.sel_somador_subtrator;
  assign CTRL_REG_DATA_RETURN  = ctrl_q.reg_data_return;
  assign SEL_MUX_STACK         = ctrl_q.sel_mux_stack;
  assign CTRL_REG_READ_STACK   = ctrl_q.reg_read_stack;
  assign CTRL_REG_WRITE_STACK  = ctrl_q.reg_write_stack;
  assign CTRL_REG_READ_MEM     = ctrl_q.reg_read_mem;
  assign CTRL_REG_WRITE_MEM    = ctrl_q.reg_write_mem;
  assign SEL_MUX_TOS           = ctrl_q.sel_mux_tos;
  assign CTRL_REG_TOS          = ctrl_q.reg_tos;
  assign SEL_TOS_UPDATER       = ctrl_q.sel_tos_updater;
  assign CTRL_STACK            = ctrl_q.stack;
  assign CTRL_MEM_EXT          = ctrl_q.mem_ext;
  assign HALT                  = ctrl_q.halt;

endmodule

// File: tb/tb_pampy_control_unit.sv
// Directed-vector bench for pampy_control_unit: per-cycle comparison of all outputs.
module tb_pampy_control_unit;

  typedef struct packed {
    logic       halt;
    logic       instr;
    logic       arg;
    logic       pc;
    logic       pc_upd;
    logic [1:0] mux;
    logic       op1;
    logic       op2;
    logic       comp;
    logic [3:0] ula;
    logic       tos_fn;
    logic       stk_fn;
    logic       somsub;
    logic       dret;
    logic [2:0] mux_stack;
    logic       rd_stk;
    logic       wr_stk;
    logic       rd_mem;
    logic       wr_mem;
    logic       mux_tos;
    logic       tos;
    logic       tos_upd;
    logic       stack;
    logic       mem_ext;
  } ov_t;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] INSTR_IN;
  logic STACK_COMP_IN, OVERFLOW_IN;
  logic CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_PC, SEL_PC_UPDATER;
  logic [1:0] SEL_MUX;
  logic CTRL_REG_OP1, CTRL_REG_OP2, CTRL_STACK_COMP;
  logic [3:0] SEL_ULA;
  logic CTRL_REG_TOS_FUNCTION, CTRL_STACK_FUNCTION, SEL_SOMADOR_SUBTRATOR, CTRL_REG_DATA_RETURN;
  logic [2:0] SEL_MUX_STACK;
  logic CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM, CTRL_REG_WRITE_MEM;
  logic SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER, CTRL_STACK, CTRL_MEM_EXT, HALT;

  int checks = 0;
  int failures = 0;
  ov_t obs;

  always #5 clk = ~clk;

  pampy_control_unit #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .INSTR_IN(INSTR_IN),
    .STACK_COMP_IN(STACK_COMP_IN), .OVERFLOW_IN(OVERFLOW_IN),
    .CTRL_REG_INSTR(CTRL_REG_INSTR), .CTRL_REG_ARG(CTRL_REG_ARG), .CTRL_REG_PC(CTRL_REG_PC),
    .SEL_PC_UPDATER(SEL_PC_UPDATER), .SEL_MUX(SEL_MUX),
    .CTRL_REG_OP1(CTRL_REG_OP1), .CTRL_REG_OP2(CTRL_REG_OP2), .CTRL_STACK_COMP(CTRL_STACK_COMP),
    .SEL_ULA(SEL_ULA), .CTRL_REG_TOS_FUNCTION(CTRL_REG_TOS_FUNCTION),
    .CTRL_STACK_FUNCTION(CTRL_STACK_FUNCTION), .SEL_SOMADOR_SUBTRATOR(SEL_SOMADOR_SUBTRATOR),
    .CTRL_REG_DATA_RETURN(CTRL_REG_DATA_RETURN), .SEL_MUX_STACK(SEL_MUX_STACK),
    .CTRL_REG_READ_STACK(CTRL_REG_READ_STACK), .CTRL_REG_WRITE_STACK(CTRL_REG_WRITE_STACK),
    .CTRL_REG_READ_MEM(CTRL_REG_READ_MEM), .CTRL_REG_WRITE_MEM(CTRL_REG_WRITE_MEM),
    .SEL_MUX_TOS(SEL_MUX_TOS), .CTRL_REG_TOS(CTRL_REG_TOS), .SEL_TOS_UPDATER(SEL_TOS_UPDATER),
    .CTRL_STACK(CTRL_STACK), .CTRL_MEM_EXT(CTRL_MEM_EXT), .HALT(HALT)
  );

  assign obs = {HALT, CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_PC, SEL_PC_UPDATER, SEL_MUX,
                CTRL_REG_OP1, CTRL_REG_OP2, CTRL_STACK_COMP, SEL_ULA,
                CTRL_REG_TOS_FUNCTION, CTRL_STACK_FUNCTION, SEL_SOMADOR_SUBTRATOR, CTRL_REG_DATA_RETURN,
                SEL_MUX_STACK, CTRL_REG_READ_STACK, CTRL_REG_WRITE_STACK, CTRL_REG_READ_MEM,
                CTRL_REG_WRITE_MEM, SEL_MUX_TOS, CTRL_REG_TOS, SEL_TOS_UPDATER, CTRL_STACK, CTRL_MEM_EXT};

  // Expected output vectors for each state, written from the state descriptions.
  function automatic ov_t e_idle();  ov_t e = '0; return e; endfunction
  function automatic ov_t e_fetch(); ov_t e = '0; e.instr = 1'b1; e.pc = 1'b1; return e; endfunction
  function automatic ov_t e_arg();   ov_t e = '0; e.arg = 1'b1; e.pc = 1'b1; return e; endfunction
  function automatic ov_t e_pop1(logic dret);
    ov_t e = '0; e.rd_stk = 1'b1; e.tos = 1'b1; e.tos_upd = 1'b1; e.op1 = 1'b1; e.dret = dret; return e;
  endfunction
  function automatic ov_t e_pop2();
    ov_t e = '0; e.rd_stk = 1'b1; e.tos = 1'b1; e.tos_upd = 1'b1; e.op2 = 1'b1; return e;
  endfunction
  function automatic ov_t e_alu(logic [3:0] ula, logic cmp);
    ov_t e = '0; e.ula = ula; e.comp = cmp; return e;
  endfunction
  function automatic ov_t e_push(logic [2:0] sel);
    ov_t e = '0; e.wr_stk = 1'b1; e.stack = 1'b1; e.tos = 1'b1; e.mux_stack = sel; return e;
  endfunction
  function automatic ov_t e_jump(); ov_t e = '0; e.pc = 1'b1; e.mux = 2'b01; return e; endfunction
  function automatic ov_t e_mem(logic rd);
    ov_t e = '0; e.rd_mem = rd; e.wr_mem = ~rd; e.mem_ext = ~rd; return e;
  endfunction
  function automatic ov_t e_call(); ov_t e = '0; e.stk_fn = 1'b1; e.tos_fn = 1'b1; return e; endfunction
  function automatic ov_t e_ret();
    ov_t e = '0; e.somsub = 1'b1; e.mux = 2'b10; e.pc = 1'b1; return e;
  endfunction
  function automatic ov_t e_halt(); ov_t e = '0; e.halt = 1'b1; return e; endfunction

  task automatic test_reset();
    ov_t seq[$];
    reset = 1'b1; INSTR_IN = 8'h09;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== e_idle()) begin
        failures++; $display("FAIL reset_hold cycle %0d: got %h want %h", i, obs, e_idle());
      end
    end
    reset = 1'b0;
    seq = '{e_fetch(), e_arg(), e_idle(), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL reset_release_nop cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_const_add();
    ov_t seq[$];
    INSTR_IN = 8'h64;
    seq = '{e_arg(), e_idle(), e_push(3'b011), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL load_const cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    INSTR_IN = 8'h17;
    seq = '{e_arg(), e_idle(), e_pop1(1'b0), e_pop2(), e_alu(4'b0000, 1'b0), e_push(3'b000), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL binary_add cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_sub_compare();
    ov_t seq[$];
    INSTR_IN = 8'h18;
    seq = '{e_arg(), e_idle(), e_pop1(1'b0), e_pop2(), e_alu(4'b0001, 1'b0), e_push(3'b000), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL binary_sub cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    INSTR_IN = 8'h6B;
    seq = '{e_arg(), e_idle(), e_pop1(1'b0), e_pop2(), e_alu(4'b0010, 1'b1), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL compare_op cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_memory();
    ov_t seq[$];
    INSTR_IN = 8'h65;
    seq = '{e_arg(), e_idle(), e_mem(1'b1), e_push(3'b001), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL load_name cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    INSTR_IN = 8'h5A;
    seq = '{e_arg(), e_idle(), e_pop1(1'b0), e_mem(1'b0), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL store_name cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_jumps();
    ov_t seq[$];
    INSTR_IN = 8'h71; STACK_COMP_IN = 1'b1;
    seq = '{e_arg(), e_idle(), e_jump(), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL jump_absolute cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    INSTR_IN = 8'h72; STACK_COMP_IN = 1'b0;
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL jif_taken cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    STACK_COMP_IN = 1'b1;
    seq = '{e_arg(), e_idle(), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL jif_not_taken cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    STACK_COMP_IN = 1'b0;
  endtask

  task automatic test_call_ret();
    ov_t seq[$];
    INSTR_IN = 8'h83;
    seq = '{e_arg(), e_idle(), e_call(), e_jump(), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL call_function cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    INSTR_IN = 8'h53;
    seq = '{e_arg(), e_idle(), e_pop1(1'b1), e_ret(), e_push(3'b010), e_fetch()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL return_value cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
  endtask

  task automatic test_halt();
    ov_t seq[$];
    INSTR_IN = 8'hFF;
    seq = '{e_arg(), e_idle()};
    for (int i = 0; i < 21; i++) seq.push_back(e_halt());
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL illegal_halt cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    INSTR_IN = 8'h09; reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== e_idle()) begin
      failures++; $display("FAIL halt_reset_clear: got %h want %h", obs, e_idle());
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== e_fetch()) begin
      failures++; $display("FAIL halt_reset_fetch: got %h want %h", obs, e_fetch());
    end
  endtask

  task automatic test_overflow();
    ov_t seq[$];
    int pushes;
    pushes = 0;
    INSTR_IN = 8'h17; OVERFLOW_IN = 1'b1;
    seq = '{e_arg(), e_idle(), e_pop1(1'b0), e_pop2(), e_alu(4'b0000, 1'b0), e_halt(), e_halt()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      if (CTRL_REG_WRITE_STACK === 1'b1) pushes++;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL overflow_seq cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    checks++;
    if (pushes !== 0) begin
      failures++; $display("FAIL overflow_no_push: got %0d pushes want 0", pushes);
    end
    OVERFLOW_IN = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== e_fetch()) begin
      failures++; $display("FAIL overflow_reset_fetch: got %h want %h", obs, e_fetch());
    end
  endtask

  task automatic test_reset_mid_pop2();
    ov_t seq[$];
    INSTR_IN = 8'h17;
    seq = '{e_arg(), e_idle(), e_pop1(1'b0), e_pop2()};
    foreach (seq[i]) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== seq[i]) begin
        failures++; $display("FAIL pre_abort cycle %0d: got %h want %h", i + 1, obs, seq[i]);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== e_idle()) begin
      failures++; $display("FAIL abort_reset_edge: got %h want %h", obs, e_idle());
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs !== e_fetch()) begin
      failures++; $display("FAIL abort_fetch: got %h want %h", obs, e_fetch());
    end
  endtask

  initial begin
    reset = 1'b1; INSTR_IN = 8'h00; STACK_COMP_IN = 1'b0; OVERFLOW_IN = 1'b0;
    test_reset();
    test_const_add();
    test_sub_compare();
    test_memory();
    test_jumps();
    test_call_ret();
    test_halt();
    test_overflow();
    test_reset_mid_pop2();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
